// File: rtl/spi_mem_bridge.sv
// SPI master bridge between the rv32e core and two SPI memories (flash/RAM).
// One CPU request becomes one SPI mode-0 transaction: opcode, 24-bit address,
// then 1/2/4 data bytes. Read results are assembled little-endian by byte.
module spi_mem_bridge #(
    parameter int         CLK_DIV   = 1,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_request,
    input  logic        is_write,
    input  logic        is_data_fetch,
    input  logic [2:0]  num_bytes,
    input  logic [31:0] target_address,
    input  logic [31:0] write_value,
    output logic [31:0] fetched_instruction,
    output logic [31:0] fetched_data,
    output logic        request_done,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs1,
    output logic        cs2
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // START is the single setup cycle between latching the request and
    // asserting chip select with the first opcode bit on mosi.
    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic [2:0]       n_q, n_d;
    logic             write_q, write_d;
    logic             fetch_q, fetch_d;
    logic             chip_q, chip_d;
    logic [63:0]      sr_q, sr_d;
    logic [31:0]      rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs1_q, cs1_d;
    logic             cs2_q, cs2_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      data_q, data_d;
    logic [5:0]       last_bit;
    logic             unused_addr;

    assign unused_addr = ^target_address[31:25];

    // Next-state logic: request latch, bit timing, shifting and result write-back.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        n_d      = n_q;
        write_d  = write_q;
        fetch_d  = fetch_q;
        chip_d   = chip_q;
        sr_d     = sr_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs1_d    = cs1_q;
        cs2_d    = cs2_q;
        instr_d  = instr_q;
        data_d   = data_q;
        last_bit = 6'd31 + {n_q, 3'b000};

        case (state_q)
            IDLE: begin
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                cs1_d  = 1'b1;
                cs2_d  = 1'b1;
                if (start_request) begin
                    write_d = is_write;
                    fetch_d = is_data_fetch;
                    chip_d  = target_address[24];
                    sr_d    = {(is_write ? CMD_WRITE : CMD_READ),
                               target_address[23:0],
                               (is_write ? write_value : 32'h0)};
                    rx_d    = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    case (num_bytes)
                        3'd0:    n_d = 3'd0;
                        3'd1:    n_d = 3'd1;
                        3'd2:    n_d = 3'd2;
                        3'd3:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                    if (num_bytes == 3'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = START;
                    end
                end
            end

            START: begin
                if (!start_request) begin
                    state_d = IDLE;
                end else begin
                    cs1_d   = chip_q;
                    cs2_d   = !chip_q;
                    mosi_d  = sr_q[63];
                    sr_d    = {sr_q[62:0], 1'b0};
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = CMD;
                end
            end

            CMD, ADDR, DATA: begin
                if (!start_request) begin
                    state_d = IDLE;
                    sclk_d  = 1'b0;
                    mosi_d  = 1'b0;
                    cs1_d   = 1'b1;
                    cs2_d   = 1'b1;
                end else if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (state_q == DATA && !write_q) begin
                            rx_d[{bit_q[4:3], ~bit_q[2:0]}] = miso;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == last_bit) begin
                            state_d = DONE;
                            mosi_d  = 1'b0;
                            cs1_d   = 1'b1;
                            cs2_d   = 1'b1;
                            if (!write_q) begin
                                if (fetch_q) begin
                                    data_d = rx_q;
                                end else begin
                                    instr_d = rx_q;
                                end
                            end
                        end else begin
                            bit_d  = bit_q + 6'd1;
                            mosi_d = sr_q[63];
                            sr_d   = {sr_q[62:0], 1'b0};
                            if (bit_q == 6'd7) begin
                                state_d = ADDR;
                            end else if (bit_q == 6'd31) begin
                                state_d = DATA;
                            end
                        end
                    end
                end
            end

            DONE: begin
                if (!start_request) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            n_q     <= '0;
            write_q <= 1'b0;
            fetch_q <= 1'b0;
            chip_q  <= 1'b0;
            sr_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs1_q   <= 1'b1;
            cs2_q   <= 1'b1;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            n_q     <= n_d;
            write_q <= write_d;
            fetch_q <= fetch_d;
            chip_q  <= chip_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs1_q   <= cs1_d;
            cs2_q   <= cs2_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

    assign fetched_instruction = instr_q;
    assign fetched_data        = data_q;
    assign request_done        = (state_q == DONE);
    assign sclk                = sclk_q;
    assign mosi                = mosi_q;
    assign cs1                 = cs1_q;
    assign cs2                 = cs2_q;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge: two instances (CLK_DIV=1 and 3),
// an SPI slave model per instance, and a scoreboard queue of expected results.
module tb_spi_mem_bridge;

    typedef struct {
        int          inst;
        logic [31:0] instr;
        logic [31:0] data;
        logic [63:0] stream;
        int          bits;
        int          chip;
        int          latency;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  start_request = '0;
    logic        is_write = 1'b0;
    logic        is_data_fetch = 1'b0;
    logic [2:0]  num_bytes = '0;
    logic [31:0] target_address = '0;
    logic [31:0] write_value = '0;
    logic [1:0]  miso = '0;
    logic [1:0]  sclk;
    logic [1:0]  mosi;
    logic [1:0]  cs1;
    logic [1:0]  cs2;
    logic [1:0]  request_done;
    logic [31:0] f_instr [2];
    logic [31:0] f_data [2];

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cycle = 0;
    int          violations = 0;
    int          start_cycle [2] = '{0, 0};
    exp_t        exp_q [$];
    logic [31:0] resp_stream = '0;

    logic [63:0] stream [2] = '{64'h0, 64'h0};
    int          rise_cnt [2] = '{0, 0};
    int          used_chip [2] = '{0, 0};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    logic        cs_prev_any [2] = '{1'b0, 1'b0};
    logic        mosi_prev [2] = '{1'b0, 1'b0};
    logic        done_prev [2] = '{1'b0, 1'b0};
    logic        run_lvl [2] = '{1'b0, 1'b0};
    int          run_len [2] = '{0, 0};
    int          hi_min [2] = '{0, 0};
    int          hi_max [2] = '{0, 0};
    int          lo_min [2] = '{0, 0};
    int          lo_max [2] = '{0, 0};

    // Instance 0 runs at full SCLK rate, instance 1 with a divider of 3.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_mem_bridge #(
            .CLK_DIV   (g == 0 ? 1 : 3),
            .CMD_READ  (8'h03),
            .CMD_WRITE (8'h02)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .start_request       (start_request[g]),
            .is_write            (is_write),
            .is_data_fetch       (is_data_fetch),
            .num_bytes           (num_bytes),
            .target_address      (target_address),
            .write_value         (write_value),
            .fetched_instruction (f_instr[g]),
            .fetched_data        (f_data[g]),
            .request_done        (request_done[g]),
            .sclk                (sclk[g]),
            .mosi                (mosi[g]),
            .miso                (miso[g]),
            .cs1                 (cs1[g]),
            .cs2                 (cs2[g])
        );
    end

    // Free-running system clock.
    always #5 clk = ~clk;

    // Counts active clock edges so latency can be measured in cycles.
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic respBit(input int i);
        if (i >= 32 && i < 64) return resp_stream[63 - i];
        return 1'b0;
    endfunction

    function automatic exp_t mkExp(input int inst, input logic [31:0] instr,
                                   input logic [31:0] data, input logic [63:0] strm,
                                   input int bits, input int chip, input int latency);
        exp_t e;
        e.inst    = inst;
        e.instr   = instr;
        e.data    = data;
        e.stream  = strm;
        e.bits    = bits;
        e.chip    = chip;
        e.latency = latency;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // SPI slave model and scoreboard monitor, sampled on the falling clk edge.
    // The slave shifts miso out on sclk falling edges (mode 0) and records
    // mosi on sclk rising edges; the monitor pops an expectation whenever
    // request_done rises.
    always @(negedge clk) begin : slave_and_monitor
        exp_t e;
        logic any_cs;
        for (int g = 0; g < 2; g++) begin
            any_cs = !cs1[g] || !cs2[g];
            if (!cs1[g] && !cs2[g]) violations++;
            if (any_cs && !cs_prev_any[g]) begin
                stream[g]    = '0;
                rise_cnt[g]  = 0;
                used_chip[g] = !cs1[g] ? 1 : 2;
                run_lvl[g]   = sclk[g];
                run_len[g]   = 1;
                hi_min[g]    = 1000;
                hi_max[g]    = 0;
                lo_min[g]    = 1000;
                lo_max[g]    = 0;
                miso[g]      = respBit(0);
            end else if (any_cs) begin
                if (sclk[g] && sclk_prev[g] && mosi[g] !== mosi_prev[g]) violations++;
                if (sclk[g] && !sclk_prev[g]) begin
                    stream[g] = {stream[g][62:0], mosi[g]};
                    rise_cnt[g]++;
                end
                if (!sclk[g] && sclk_prev[g]) miso[g] = respBit(rise_cnt[g]);
                if (sclk[g] == run_lvl[g]) begin
                    run_len[g]++;
                end else begin
                    if (run_lvl[g]) begin
                        if (run_len[g] < hi_min[g]) hi_min[g] = run_len[g];
                        if (run_len[g] > hi_max[g]) hi_max[g] = run_len[g];
                    end else begin
                        if (run_len[g] < lo_min[g]) lo_min[g] = run_len[g];
                        if (run_len[g] > lo_max[g]) lo_max[g] = run_len[g];
                    end
                    run_lvl[g] = sclk[g];
                    run_len[g] = 1;
                end
            end
            if (request_done[g] && !done_prev[g]) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected request_done on instance %0d", g);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("instance", 64'(g), 64'(e.inst));
                    checkOutput("fetched_instruction", {32'h0, f_instr[g]}, {32'h0, e.instr});
                    checkOutput("fetched_data", {32'h0, f_data[g]}, {32'h0, e.data});
                    checkOutput("mosi stream", stream[g], e.stream);
                    checkOutput("sclk rising edges", 64'(rise_cnt[g]), 64'(e.bits));
                    checkOutput("chip select used", 64'(used_chip[g]), 64'(e.chip));
                    checkOutput("done latency", 64'(cycle - start_cycle[g]), 64'(e.latency));
                end
                stream[g]    = '0;
                rise_cnt[g]  = 0;
                used_chip[g] = 0;
            end
            sclk_prev[g]   = sclk[g];
            cs_prev_any[g] = any_cs;
            mosi_prev[g]   = mosi[g];
            done_prev[g]   = request_done[g];
        end
    end

    // Issues one complete request with handshake; latency counts clk edges
    // after the edge that samples start_request.
    task automatic applyStimulus(input int g, input logic wr, input logic df,
                                 input logic [2:0] nb, input logic [31:0] addr,
                                 input logic [31:0] wval, input logic [31:0] resp,
                                 input exp_t e);
        int waited;
        exp_q.push_back(e);
        @(negedge clk);
        resp_stream      = resp;
        is_write         = wr;
        is_data_fetch    = df;
        num_bytes        = nb;
        target_address   = addr;
        write_value      = wval;
        start_request[g] = 1'b1;
        @(posedge clk);
        #1;
        start_cycle[g] = cycle;
        waited = 0;
        while (!request_done[g] && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!request_done[g]) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL request timeout on instance %0d: got done=0, expected done=1", g);
        end
        repeat (3) @(negedge clk);
        checkOutput("request_done held", 64'(request_done[g]), 64'd1);
        start_request[g] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("request_done cleared", 64'(request_done[g]), 64'd0);
        @(negedge clk);
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int waited;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset cs1", 64'(cs1[0]), 64'd1);
        checkOutput("reset cs2", 64'(cs2[0]), 64'd1);
        checkOutput("reset sclk", 64'(sclk[0]), 64'd0);
        checkOutput("reset mosi", 64'(mosi[0]), 64'd0);
        checkOutput("reset request_done", 64'(request_done[0]), 64'd0);
        checkOutput("reset fetched_instruction", {32'h0, f_instr[0]}, 64'h0);
        checkOutput("reset fetched_data", {32'h0, f_data[0]}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Instruction fetch of 4 bytes from flash.
        applyStimulus(0, 1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'h0, 32'h1305_5000,
                      mkExp(0, 32'h0050_0513, 32'h0, 64'h0300_0010_0000_0000, 64, 1, 129));
        // Two-byte store to the second chip.
        applyStimulus(0, 1'b1, 1'b0, 3'd2, 32'h0100_0020, 32'hBEEF_0000, 32'h0,
                      mkExp(0, 32'h0050_0513, 32'h0, 64'h0000_0200_0020_BEEF, 48, 2, 97));
        // Single-byte data load.
        applyStimulus(0, 1'b0, 1'b1, 3'd1, 32'h0000_0104, 32'h0, 32'hF0A5_A5A5,
                      mkExp(0, 32'h0050_0513, 32'h0000_00F0, 64'h0000_0003_0001_0400, 40, 1, 81));
        // num_bytes=3 clamps to 2 bytes; upper address bits ignored.
        applyStimulus(0, 1'b0, 1'b1, 3'd3, 32'h01AB_CDEF, 32'h0, 32'h1234_5678,
                      mkExp(0, 32'h0050_0513, 32'h0000_3412, 64'h0000_03AB_CDEF_0000, 48, 2, 97));

        // Abort a 4-byte read after 10 sclk rising edges.
        @(negedge clk);
        resp_stream      = 32'h1111_1111;
        is_write         = 1'b0;
        is_data_fetch    = 1'b0;
        num_bytes        = 3'd4;
        target_address   = 32'h0000_0040;
        start_request[0] = 1'b1;
        waited = 0;
        while (rise_cnt[0] < 10 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("abort reached 10 sclk edges", 64'(rise_cnt[0] >= 10), 64'd1);
        start_request[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort cs1", 64'(cs1[0]), 64'd1);
        checkOutput("abort cs2", 64'(cs2[0]), 64'd1);
        checkOutput("abort sclk", 64'(sclk[0]), 64'd0);
        checkOutput("abort request_done", 64'(request_done[0]), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort request_done later", 64'(request_done[0]), 64'd0);
        checkOutput("abort fetched_instruction", {32'h0, f_instr[0]}, 64'h0050_0513);
        checkOutput("abort fetched_data", {32'h0, f_data[0]}, 64'h0000_3412);
        applyStimulus(0, 1'b0, 1'b1, 3'd2, 32'h0000_0200, 32'h0, 32'hCAFE_0000,
                      mkExp(0, 32'h0050_0513, 32'h0000_FECA, 64'h0000_0300_0200_0000, 48, 1, 97));

        // Asynchronous reset in the middle of the data phase.
        @(negedge clk);
        resp_stream      = 32'h5555_AAAA;
        is_write         = 1'b0;
        is_data_fetch    = 1'b0;
        num_bytes        = 3'd4;
        target_address   = 32'h0000_0080;
        start_request[0] = 1'b1;
        waited = 0;
        while (rise_cnt[0] < 40 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async reset cs1", 64'(cs1[0]), 64'd1);
        checkOutput("async reset cs2", 64'(cs2[0]), 64'd1);
        checkOutput("async reset sclk", 64'(sclk[0]), 64'd0);
        checkOutput("async reset request_done", 64'(request_done[0]), 64'd0);
        checkOutput("async reset fetched_instruction", {32'h0, f_instr[0]}, 64'h0);
        checkOutput("async reset fetched_data", {32'h0, f_data[0]}, 64'h0);
        start_request[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Divider of 3: zero-byte request completes without chip select.
        applyStimulus(1, 1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0, 32'h0,
                      mkExp(1, 32'h0, 32'h0, 64'h0, 0, 0, 0));
        // num_bytes=7 clamps to 4 bytes.
        applyStimulus(1, 1'b0, 1'b1, 3'd7, 32'h0100_0004, 32'h0, 32'hDEAD_BEEF,
                      mkExp(1, 32'h0, 32'hEFBE_ADDE, 64'h0300_0004_0000_0000, 64, 2, 385));
        checkOutput("div3 sclk high min", 64'(hi_min[1]), 64'd3);
        checkOutput("div3 sclk high max", 64'(hi_max[1]), 64'd3);
        checkOutput("div3 sclk low min", 64'(lo_min[1]), 64'd3);
        checkOutput("div3 sclk low max", 64'(lo_max[1]), 64'd3);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 64'(exp_q.size()), 64'd0);
        checkOutput("cs exclusivity and mosi stability", 64'(violations), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
